// File: rtl/lpc_frame_ring.sv
// ---------------------------------------------------------------------------
// lpc_frame_ring
//
// Captures decoded LPC cycles and packs each one into an 8-byte frame slot of
// an internal ring. The serial stage reads the oldest committed frame through
// an asynchronous byte port and frees the slot with a rising edge on read_done.
//
// Frame layout (byte offset within a slot):
//   0: {3'b0, dir, cyctype}   1..4: addr[31:24] .. addr[7:0]   5: data
//   6: {ovf_pend, seq[6:0]}   7: 8'h00
//
// Handshakes:
//   Capture side: frame_valid is a single-cycle pulse with no backpressure.
//   A frame is taken only when the writer is idle and the ring is not full;
//   otherwise it is dropped, counted, and flagged in the next committed frame.
//   Read side: read_empty = 0 means the slot at target_addr holds a committed
//   frame. A rising edge on read_done retires it; read_empty rises in that
//   same cycle so the serial stage never re-sends the completed frame.
//
// Ports:
//   clock, reset          clock; asynchronous active-low reset
//   frame_valid/_cyctype/_dir/_addr/_data   decoded LPC cycle input
//   read_addr, read_data  async byte read port {slot, byte}
//   target_addr           slot index of the oldest committed frame
//   read_empty, read_done read handshake with the serial stage
//   wr_busy               high while a frame is being written/committed
//   dropped_count         saturating count of lost frames
//   wr_state              write FSM state (debug observation)
// ---------------------------------------------------------------------------
module lpc_frame_ring #(
    parameter int AW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          frame_valid,
    input  logic [3:0]    frame_cyctype,
    input  logic          frame_dir,
    input  logic [31:0]   frame_addr,
    input  logic [7:0]    frame_data,
    input  logic [AW-1:0] read_addr,
    output logic [7:0]    read_data,
    output logic [AW-4:0] target_addr,
    output logic          read_empty,
    input  logic          read_done,
    output logic          wr_busy,
    output logic [7:0]    dropped_count,
    output logic [1:0]    wr_state
);

    localparam int SW = AW - 3;  // slot index width

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state, next_state;

    // Pointers carry one extra wrap bit above the slot index.
    logic [SW:0]  wr_ptr, rd_ptr;
    logic [2:0]   cnt;
    logic [6:0]   seq;
    logic         ovf_pend;
    logic         done_q;

    logic [3:0]   cyc_q;
    logic         dir_q;
    logic [31:0]  addr_q;
    logic [7:0]   data_q;

    logic [7:0]   mem [0:(1<<AW)-1];

    logic         empty, full;
    logic         accept, drop, advance;
    logic         wr_en, commit;
    logic [7:0]   wr_byte;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[SW-1:0] == rd_ptr[SW-1:0]) && (wr_ptr[SW] != rd_ptr[SW]);
    assign accept  = frame_valid && (state == IDLE) && !full;
    assign drop    = frame_valid && !accept;
    assign advance = read_done && !done_q;

    // ---------------- write FSM: state register ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // ---------------- write FSM: next state ----------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = WRITE;
            WRITE:   if (cnt == 3'd7) next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ---------------- write FSM: outputs ----------------
    always_comb begin
        wr_busy = 1'b0;
        wr_en   = 1'b0;
        commit  = 1'b0;
        case (state)
            WRITE:   begin wr_busy = 1'b1; wr_en  = 1'b1; end
            COMMIT:  begin wr_busy = 1'b1; commit = 1'b1; end
            default: ;
        endcase
    end

    assign wr_state = state;

    // Byte being written this cycle, selected by the byte counter.
    always_comb begin
        wr_byte = 8'h00;
        case (cnt)
            3'd0:    wr_byte = {3'b000, dir_q, cyc_q};
            3'd1:    wr_byte = addr_q[31:24];
            3'd2:    wr_byte = addr_q[23:16];
            3'd3:    wr_byte = addr_q[15:8];
            3'd4:    wr_byte = addr_q[7:0];
            3'd5:    wr_byte = data_q;
            3'd6:    wr_byte = {ovf_pend, seq};
            default: wr_byte = 8'h00;
        endcase
    end

    // ---------------- datapath and pointers ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            cnt           <= 3'd0;
            seq           <= 7'd0;
            ovf_pend      <= 1'b0;
            done_q        <= 1'b0;
            dropped_count <= 8'd0;
            cyc_q         <= 4'd0;
            dir_q         <= 1'b0;
            addr_q        <= 32'd0;
            data_q        <= 8'd0;
        end else begin
            done_q <= read_done;

            if (accept) begin
                cyc_q  <= frame_cyctype;
                dir_q  <= frame_dir;
                addr_q <= frame_addr;
                data_q <= frame_data;
            end

            // Counter runs 0..7 during WRITE and rests at 0 otherwise.
            cnt <= wr_en ? cnt + 3'd1 : 3'd0;

            if (commit) begin
                wr_ptr <= wr_ptr + 1'b1;
                seq    <= seq + 7'd1;
            end

            // A drop in the COMMIT cycle must flag the following frame.
            if (drop)        ovf_pend <= 1'b1;
            else if (commit) ovf_pend <= 1'b0;

            if (drop && dropped_count != 8'hFF)
                dropped_count <= dropped_count + 8'd1;

            // A spurious done on an empty ring must not pass wr_ptr.
            if (advance && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Frame storage is not reset; only committed slots are ever exposed.
    always_ff @(posedge clock) begin
        if (wr_en)
            mem[{wr_ptr[SW-1:0], cnt}] <= wr_byte;
    end

    assign read_data   = mem[read_addr];
    assign target_addr = rd_ptr[SW-1:0];
    assign read_empty  = empty || advance;

endmodule

// File: tb/tb_lpc_frame_ring.sv
module tb_lpc_frame_ring;

    localparam int AW = 8;

    logic          clock;
    logic          reset;
    logic          frame_valid;
    logic [3:0]    frame_cyctype;
    logic          frame_dir;
    logic [31:0]   frame_addr;
    logic [7:0]    frame_data;
    logic [AW-1:0] read_addr;
    logic [7:0]    read_data;
    logic [AW-4:0] target_addr;
    logic          read_empty;
    logic          read_done;
    logic          wr_busy;
    logic [7:0]    dropped_count;
    logic [1:0]    wr_state;

    int checks = 0;
    int errors = 0;

    lpc_frame_ring #(.AW(AW)) dut (
        .clock         (clock),
        .reset         (reset),
        .frame_valid   (frame_valid),
        .frame_cyctype (frame_cyctype),
        .frame_dir     (frame_dir),
        .frame_addr    (frame_addr),
        .frame_data    (frame_data),
        .read_addr     (read_addr),
        .read_data     (read_data),
        .target_addr   (target_addr),
        .read_empty    (read_empty),
        .read_done     (read_done),
        .wr_busy       (wr_busy),
        .dropped_count (dropped_count),
        .wr_state      (wr_state)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #10 clock = ~clock;

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        frame_valid   = 1'b0;
        frame_cyctype = 4'h0;
        frame_dir     = 1'b0;
        frame_addr    = 32'h0;
        frame_data    = 8'h0;
        read_addr     = '0;
        read_done     = 1'b0;
        ticks(2);
        reset = 1'b1;
        tick();
    endtask

    // Presents a one-cycle frame_valid pulse; returns just after the sampling edge.
    task automatic send_frame(input logic [3:0] c, input logic d,
                              input logic [31:0] a, input logic [7:0] dt);
        frame_cyctype = c;
        frame_dir     = d;
        frame_addr    = a;
        frame_data    = dt;
        frame_valid   = 1'b1;
        tick();
        frame_valid   = 1'b0;
    endtask

    task automatic pulse_done();
        read_done = 1'b1;
        tick();
        read_done = 1'b0;
        tick();
    endtask

    task automatic check_byte(input string tag, input logic [4:0] slot,
                              input logic [2:0] b, input logic [7:0] exp);
        read_addr = {slot, b};
        #1;
        check(tag, read_data, exp);
    endtask

    task automatic check_frame(input string tag, input logic [4:0] slot,
                               input logic [63:0] exp);
        logic [63:0] e;
        e = exp;
        for (int b = 0; b < 8; b++)
            check_byte(tag, slot, b[2:0], e[63-8*b -: 8]);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Test 1: reset state, single frame latency and layout
        do_reset();
        check("rst_empty",   read_empty, 1);
        check("rst_target",  target_addr, 0);
        check("rst_dropped", dropped_count, 0);
        check("rst_busy",    wr_busy, 0);
        check("rst_state",   wr_state, 0);

        send_frame(4'h0, 1'b1, 32'h0000_0080, 8'hA5);
        check("t1_busy_write", wr_busy, 1);
        check("t1_state_write", wr_state, 1);
        ticks(8);
        check("t1_state_commit", wr_state, 2);
        check("t1_empty_before", read_empty, 1);
        tick();
        check("t1_empty_after", read_empty, 0);
        check("t1_busy_idle", wr_busy, 0);
        check_frame("t1_frame", 5'd0, 64'h10_00_00_00_80_A5_00_00);

        // Test 2: retire handshake, single advance per rising edge
        send_frame(4'h3, 1'b0, 32'h0000_00F0, 8'h11);
        ticks(9);
        check_byte("t2_seq1", 5'd1, 3'd6, 8'h01);
        read_done = 1'b1;
        #1;
        check("t2_empty_same_cycle", read_empty, 1);
        check("t2_target_before", target_addr, 0);
        tick();
        check("t2_target_next", target_addr, 1);
        check("t2_empty_next", read_empty, 0);
        ticks(3);
        check("t2_held_target", target_addr, 1);
        read_done = 1'b0;
        tick();
        pulse_done();
        check("t2_target2", target_addr, 2);
        check("t2_empty2", read_empty, 1);
        pulse_done();
        check("t2_spurious_target", target_addr, 2);
        check("t2_spurious_empty", read_empty, 1);

        // Test 3: fill 32 frames, drop the 33rd, overflow flag on the next
        do_reset();
        for (int i = 0; i < 32; i++) begin
            send_frame(4'h1, 1'b0, 32'h100 + i, i[7:0]);
            ticks(9);
        end
        check("t3_full_not_empty", read_empty, 0);
        check("t3_target", target_addr, 0);
        check_byte("t3_slot31_data", 5'd31, 3'd5, 8'd31);
        send_frame(4'h1, 1'b0, 32'hDEAD, 8'hEE);
        check("t3_drop_busy", wr_busy, 0);
        check("t3_dropped", dropped_count, 1);
        ticks(10);
        check_byte("t3_slot0_kept", 5'd0, 3'd5, 8'd0);
        pulse_done();
        check("t3_target_after_read", target_addr, 1);
        send_frame(4'h2, 1'b1, 32'hCAFE_0001, 8'h5A);
        ticks(9);
        check_byte("t3_new_data", 5'd0, 3'd5, 8'h5A);
        check_byte("t3_ovf_seq32", 5'd0, 3'd6, 8'hA0);

        // Test 4: frame_valid during WRITE is dropped; seq counts accepted frames
        do_reset();
        send_frame(4'h2, 1'b0, 32'h1234_5678, 8'h3C);
        ticks(2);
        send_frame(4'h7, 1'b1, 32'hFFFF_FFFF, 8'hFF);
        check("t4_dropped", dropped_count, 1);
        ticks(6);
        check("t4_visible", read_empty, 0);
        check_frame("t4_frame0", 5'd0, 64'h02_12_34_56_78_3C_80_00);
        send_frame(4'h2, 1'b0, 32'h0000_0001, 8'h01);
        ticks(9);
        check_byte("t4_seq1", 5'd1, 3'd6, 8'h01);
        send_frame(4'h2, 1'b0, 32'h0000_0002, 8'h02);
        ticks(9);
        check_byte("t4_seq2", 5'd2, 3'd6, 8'h02);
        check("t4_dropped_final", dropped_count, 1);

        // Test 5: 40 frames one at a time across the wrap
        do_reset();
        for (int i = 0; i < 40; i++) begin
            send_frame(4'h0, 1'b0, 32'h200 + i, i[7:0]);
            ticks(9);
            check("t5_not_empty", read_empty, 0);
            check("t5_target", target_addr, i % 32);
            check_byte("t5_data", target_addr, 3'd5, i[7:0]);
            pulse_done();
            check("t5_empty", read_empty, 1);
        end
        check("t5_no_drops", dropped_count, 0);
        check("t5_target_wrapped", target_addr, 8);

        // Simultaneous COMMIT and advance keep occupancy at one
        send_frame(4'h0, 1'b1, 32'h300, 8'hC1);
        ticks(9);
        send_frame(4'h0, 1'b1, 32'h301, 8'hC2);
        ticks(8);
        check("t5_sim_state", wr_state, 2);
        read_done = 1'b1;
        tick();
        check("t5_sim_not_empty", read_empty, 0);
        check("t5_sim_target", target_addr, 9);
        check_byte("t5_sim_data", 5'd9, 3'd5, 8'hC2);
        read_done = 1'b0;
        tick();
        pulse_done();
        check("t5_sim_drained", read_empty, 1);
        check("t5_sim_target2", target_addr, 10);

        // Test 6: reset in the middle of a WRITE
        do_reset();
        send_frame(4'h0, 1'b1, 32'h400, 8'h77);
        send_frame(4'h0, 1'b1, 32'h401, 8'h78);
        ticks(2);
        check("t6_pre_state", wr_state, 1);
        check("t6_pre_dropped", dropped_count, 1);
        reset = 1'b0;
        #1;
        check("t6_async_busy", wr_busy, 0);
        tick();
        reset = 1'b1;
        tick();
        check("t6_empty", read_empty, 1);
        check("t6_target", target_addr, 0);
        check("t6_dropped", dropped_count, 0);
        check("t6_busy", wr_busy, 0);
        ticks(10);
        check("t6_never_committed", read_empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
